// File: rtl/acc_cpu_controller.sv
// Multicycle fetch/decode/execute controller for the 16-bit accumulator CPU.
// Owns PC/IR/MBR/AC and sequences the synchronous RAM and the external ALU.
`timescale 1ns/1ps
module acc_cpu_controller #(
  parameter int          ADDR_WIDTH = 18,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] RESET_PC   = 16'h0100,
  parameter int          MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [15:0]           pc_o,
  output logic [DATA_WIDTH-1:0] ac_o,
  output logic                  halted,
  output logic                  retire
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_FWAIT  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_OPRD   = 4'd4;
  localparam logic [3:0] S_OWAIT  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_STORE  = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam int              CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

  logic [3:0]                   state;
  logic [15:0]                  pc;
  logic [DATA_WIDTH-1:0]        ir;
  logic [DATA_WIDTH-1:0]        mbr;
  logic signed [DATA_WIDTH-1:0] ac;
  logic [CNT_W-1:0]             wait_cnt;
  logic [3:0]                   opcode;
  logic [ADDR_WIDTH-1:0]        pc_addr;
  logic [ADDR_WIDTH-1:0]        oper_addr;

  assign opcode    = ir[15:12];
  assign pc_addr   = ADDR_WIDTH'(pc);
  assign oper_addr = ADDR_WIDTH'(ir[11:0]);

  function automatic logic skip_taken(input logic [1:0] cond,
                                      input logic signed [DATA_WIDTH-1:0] acc);
    logic neg, zero;
    neg  = acc[DATA_WIDTH-1];
    zero = (acc == '0);
    case (cond)
      2'b00:   skip_taken = neg;
      2'b01:   skip_taken = zero;
      2'b10:   skip_taken = !neg && !zero;
      default: skip_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_sel_of(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel_of = 2'b01;
      OP_SUB:  alu_sel_of = 2'b10;
      OP_AND:  alu_sel_of = 2'b11;
      default: alu_sel_of = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      mbr      <= '0;
      ac       <= '0;
      wait_cnt <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= 2'b00;
      retire   <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_FWAIT;
        end
        S_FWAIT: begin
          if (wait_cnt == '0) begin
            ir    <= mem_rdata;
            pc    <= pc + 16'd1;
            state <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_DECODE: begin
          // Single-cycle instructions (and HALT) retire straight out of decode.
          retire <= 1'b1;
          state  <= S_FETCH;
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              retire <= 1'b0;
              state  <= S_OPRD;
            end
            OP_STORE: begin
              retire <= 1'b0;
              state  <= S_STORE;
            end
            OP_HALT:  state <= S_HALT;
            OP_SKIP:  if (skip_taken(ir[11:10], ac)) pc <= pc + 16'd1;
            OP_JUMP:  pc <= {4'h0, ir[11:0]};
            OP_CLEAR: ac <= '0;
            default:  ;
          endcase
        end
        S_OPRD: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_OWAIT;
        end
        S_OWAIT: begin
          if (wait_cnt == '0) begin
            // ALU operands are registered here so they are stable through EXEC and held after.
            mbr     <= mem_rdata;
            alu_a   <= ac;
            alu_b   <= mem_rdata;
            alu_sel <= alu_sel_of(opcode);
            state   <= S_EXEC;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_EXEC: begin
          ac     <= (opcode == OP_LOAD) ? mbr : alu_out;
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_STORE: begin
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_FETCH, S_FWAIT: begin
        mem_addr = pc_addr;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
      end
      S_OPRD, S_OWAIT: begin
        mem_addr = oper_addr;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
      end
      S_STORE: begin
        // Reset gates the write strobe so a store caught by reset never lands in RAM.
        mem_addr  = oper_addr;
        mem_cs    = !rst;
        mem_we    = !rst;
        mem_wdata = ac;
      end
      default: ;
    endcase
  end

  assign halted = (state == S_HALT);
  assign pc_o   = pc;
  assign ac_o   = ac;

endmodule
